// File: rtl/btn_debounce_sync.sv
// Button synchroniser + debounce FSM with registered edge pulses.
// Optional long-press detector enabled by defining BTN_LONGPRESS_EN.
module btn_debounce_sync #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LONG_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic long_press
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync0_q, sync1_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_out_q, d_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

`ifdef BTN_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
  logic long_q, long_d;
`endif

  // Two-flop synchroniser; nothing downstream looks at btn_in directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= btn_in;
      sync1_q <= sync0_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef BTN_LONGPRESS_EN
    long_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (sync1_q) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!sync1_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HIGH;
          d_out_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (!sync1_q) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end else begin
`ifdef BTN_LONGPRESS_EN
          // Saturating hold counter gives one pulse per press
          if (cnt_q < LONG_MAX) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LONG_MAX - 1'b1)
              long_d = 1'b1;
          end
`endif
        end
      end
      CHK_LO: begin
        if (sync1_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          d_out_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_out_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

`ifdef BTN_LONGPRESS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) long_q <= 1'b0;
    else     long_q <= long_d;
  end
  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

  assign d_out      = d_out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule
